// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: widths, ALU op codes, decoded control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RA_W_DEF   = 5;
    localparam int CTRL_W_DEF = 6;

    localparam logic [CTRL_W_DEF-1:0] ALU_NOP = 6'd0;
    localparam logic [CTRL_W_DEF-1:0] ALU_ADD = 6'd1;
    localparam logic [CTRL_W_DEF-1:0] ALU_SUB = 6'd2;
    localparam logic [CTRL_W_DEF-1:0] ALU_ST  = 6'd3;

    // Decoded control bits that travel with an instruction down the pipe.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

endpackage

// File: rtl/fwd_mux.sv
// ALU operand select: EX/MEM result, MEM/WB data, or the registered raw operand.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the operand is zeroed when the EX slot holds no valid instruction.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF
) (
    input  logic              en,
    input  logic [RA_W-1:0]   src_addr,
    input  logic [DATA_W-1:0] raw_dat,
    input  logic              exm_vld,
    input  logic              exm_reg_write,
    input  logic [RA_W-1:0]   exm_rd_addr,
    input  logic [DATA_W-1:0] exm_dat,
    input  logic              mwb_vld,
    input  logic              mwb_reg_write,
    input  logic [RA_W-1:0]   mwb_rd_addr,
    input  logic [DATA_W-1:0] mwb_dat,
    output logic [DATA_W-1:0] opnd_dat
);

    logic exm_hit;
    logic mwb_hit;

    // Register 0 is hardwired zero, so a write to it must never be forwarded.
    assign exm_hit = exm_vld & exm_reg_write & (exm_rd_addr != '0) & (exm_rd_addr == src_addr);
    assign mwb_hit = mwb_vld & mwb_reg_write & (mwb_rd_addr != '0) & (mwb_rd_addr == src_addr);

    // Youngest producer (EX/MEM) wins over MEM/WB; invalid EX slot drives zero.
    always_comb begin
        opnd_dat = '0;
        if (!en) begin
            opnd_dat = '0;
        end else if (exm_hit) begin
            opnd_dat = exm_dat;
        end else if (mwb_hit) begin
            opnd_dat = mwb_dat;
        end else begin
            opnd_dat = raw_dat;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and branch flush.
// Latency: one cycle from decode to ex_* outputs; forwarding adds no cycles.
// Backpressure: stall_out holds PC and IF/ID for one cycle on a load-use hazard while a bubble issues.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_alu_control,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [RA_W-1:0]   id_rs1_addr,
    input  logic [RA_W-1:0]   id_rs2_addr,
    input  logic [RA_W-1:0]   id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              exm_valid,
    input  logic              exm_reg_write,
    input  logic [RA_W-1:0]   exm_rd_addr,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_valid,
    input  logic              mwb_reg_write,
    input  logic [RA_W-1:0]   mwb_rd_addr,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_alu_control,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [RA_W-1:0]   ex_rd_addr,
    output logic              stall_out,
    output logic [CNT_W-1:0]  stall_count
);

    ctrl_t             ctrl_d,      ctrl_q;
    logic [CTRL_W-1:0] alu_ctrl_d,  alu_ctrl_q;
    logic [DATA_W-1:0] rs1_data_d,  rs1_data_q;
    logic [DATA_W-1:0] rs2_data_d,  rs2_data_q;
    logic [DATA_W-1:0] imm_d,       imm_q;
    logic [RA_W-1:0]   rs1_addr_d,  rs1_addr_q;
    logic [RA_W-1:0]   rs2_addr_d,  rs2_addr_q;
    logic [RA_W-1:0]   rd_addr_d,   rd_addr_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
    logic              hazard;

    // A load in EX whose destination is read by the decode instruction cannot be forwarded in time.
    assign hazard = ctrl_q.valid & ctrl_q.mem_read & (rd_addr_q != '0) & id_valid &
                    ((rd_addr_q == id_rs1_addr) | (rd_addr_q == id_rs2_addr));

    // A taken branch kills the decode slot, so there is nothing to hold.
    assign stall_out = hazard & ~flush & ~reset;

    // Next EX contents: flush bubble, then hazard bubble (with count), else capture decode.
    always_comb begin
        ctrl_d      = CTRL_BUBBLE;
        alu_ctrl_d  = '0;
        rs1_data_d  = '0;
        rs2_data_d  = '0;
        imm_d       = '0;
        rs1_addr_d  = '0;
        rs2_addr_d  = '0;
        rd_addr_d   = '0;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = stall_cnt_q;
        end else if (hazard) begin
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            ctrl_d.valid     = id_valid;
            ctrl_d.reg_write = id_reg_write;
            ctrl_d.mem_read  = id_mem_read;
            ctrl_d.mem_write = id_mem_write;
            alu_ctrl_d       = id_alu_control;
            rs1_data_d       = id_rs1_data;
            rs2_data_d       = id_rs2_data;
            imm_d            = id_imm;
            rs1_addr_d       = id_rs1_addr;
            rs2_addr_d       = id_rs2_addr;
            rd_addr_d        = id_rd_addr;
        end
    end

    // Pipeline register; reset overrides flush and stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= CTRL_BUBBLE;
            alu_ctrl_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_a (
        .en            (ctrl_q.valid),
        .src_addr      (rs1_addr_q),
        .raw_dat       (rs1_data_q),
        .exm_vld       (exm_valid),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_dat       (exm_result),
        .mwb_vld       (mwb_valid),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd_addr   (mwb_rd_addr),
        .mwb_dat       (mwb_data),
        .opnd_dat      (ex_a)
    );

    fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_b (
        .en            (ctrl_q.valid),
        .src_addr      (rs2_addr_q),
        .raw_dat       (rs2_data_q),
        .exm_vld       (exm_valid),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_dat       (exm_result),
        .mwb_vld       (mwb_valid),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd_addr   (mwb_rd_addr),
        .mwb_dat       (mwb_data),
        .opnd_dat      (ex_b)
    );

    assign ex_imm         = imm_q;
    assign ex_alu_control = alu_ctrl_q;
    assign ex_valid       = ctrl_q.valid;
    assign ex_reg_write   = ctrl_q.reg_write;
    assign ex_mem_read    = ctrl_q.mem_read;
    assign ex_mem_write   = ctrl_q.mem_write;
    assign ex_rd_addr     = rd_addr_q;
    assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: driver pushes expected EX-side state per cycle, monitor checks it.
// Latency: expectations are tagged with the cycle (posedge count) in which they must hold.
// Backpressure: stall_out is checked as part of every expectation record.
module tb_id_ex_stage;

    // Narrow counter so saturation is reachable quickly: every stall costs two cycles.
    localparam int CNT_W  = 8;
    localparam int DATA_W = 32;
    localparam int RA_W   = 5;
    localparam int CTRL_W = 6;

    logic              clk;
    logic              reset;
    logic              id_valid;
    logic [CTRL_W-1:0] id_alu_control;
    logic [DATA_W-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [RA_W-1:0]   id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic              id_reg_write, id_mem_read, id_mem_write;
    logic              flush;
    logic              exm_valid, exm_reg_write;
    logic [RA_W-1:0]   exm_rd_addr;
    logic [DATA_W-1:0] exm_result;
    logic              mwb_valid, mwb_reg_write;
    logic [RA_W-1:0]   mwb_rd_addr;
    logic [DATA_W-1:0] mwb_data;
    logic [DATA_W-1:0] ex_a, ex_b, ex_imm;
    logic [CTRL_W-1:0] ex_alu_control;
    logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [RA_W-1:0]   ex_rd_addr;
    logic              stall_out;
    logic [CNT_W-1:0]  stall_count;

    id_ex_stage #(.DATA_W(DATA_W), .RA_W(RA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_alu_control(id_alu_control),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
        .mwb_valid(mwb_valid), .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr), .mwb_data(mwb_data),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_alu_control(ex_alu_control),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_rd_addr(ex_rd_addr), .stall_out(stall_out), .stall_count(stall_count)
    );

    typedef struct {
        int               cyc;
        string            nm;
        logic             vld, rw, mr, mw, stall;
        logic [CTRL_W-1:0] alu;
        logic [RA_W-1:0]  rd;
        logic [DATA_W-1:0] a, b, imm;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic [CNT_W-1:0] exp_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", nm, fld, act, want);
        end
    endfunction

    // Monitor: compare the record due in this cycle against the DUT outputs.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s missed (due cycle %0d, now %0d)", e.nm, e.cyc, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk(e.nm, "ex_valid",       32'(ex_valid),       32'(e.vld));
            chk(e.nm, "ex_alu_control", 32'(ex_alu_control), 32'(e.alu));
            chk(e.nm, "ex_reg_write",   32'(ex_reg_write),   32'(e.rw));
            chk(e.nm, "ex_mem_read",    32'(ex_mem_read),    32'(e.mr));
            chk(e.nm, "ex_mem_write",   32'(ex_mem_write),   32'(e.mw));
            chk(e.nm, "ex_rd_addr",     32'(ex_rd_addr),     32'(e.rd));
            chk(e.nm, "ex_a",           ex_a,                e.a);
            chk(e.nm, "ex_b",           ex_b,                e.b);
            chk(e.nm, "ex_imm",         ex_imm,              e.imm);
            chk(e.nm, "stall_out",      32'(stall_out),      32'(e.stall));
            chk(e.nm, "stall_count",    32'(stall_count),    32'(e.cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [CTRL_W-1:0] alu,
                          input logic [RA_W-1:0] r1a, input logic [DATA_W-1:0] r1d,
                          input logic [RA_W-1:0] r2a, input logic [DATA_W-1:0] r2d,
                          input logic [DATA_W-1:0] imm, input logic [RA_W-1:0] rd,
                          input logic rw, input logic mr, input logic mw);
        id_valid = v; id_alu_control = alu;
        id_rs1_addr = r1a; id_rs1_data = r1d;
        id_rs2_addr = r2a; id_rs2_data = r2d;
        id_imm = imm; id_rd_addr = rd;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic set_exm(input logic v, input logic rw, input logic [RA_W-1:0] rd, input logic [DATA_W-1:0] d);
        exm_valid = v; exm_reg_write = rw; exm_rd_addr = rd; exm_result = d;
    endtask

    task automatic set_mwb(input logic v, input logic rw, input logic [RA_W-1:0] rd, input logic [DATA_W-1:0] d);
        mwb_valid = v; mwb_reg_write = rw; mwb_rd_addr = rd; mwb_data = d;
    endtask

    task automatic expect_now(input string nm, input logic vld, input logic [CTRL_W-1:0] alu,
                              input logic rw, input logic mr, input logic mw, input logic [RA_W-1:0] rd,
                              input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                              input logic [DATA_W-1:0] imm, input logic stall, input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.cyc = cyc; e.nm = nm;
        e.vld = vld; e.alu = alu; e.rw = rw; e.mr = mr; e.mw = mw; e.rd = rd;
        e.a = a; e.b = b; e.imm = imm; e.stall = stall; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Bound the whole run in case the clock or driver stalls.
    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Driver: each window sets the inputs for the next edge and states what must hold now.
    initial begin
        reset = 1'b1; flush = 1'b0;
        set_exm(0, 0, 0, 0);
        set_mwb(0, 0, 0, 0);
        set_id(1, 6'd1, 5'd1, 32'd5, 5'd2, 32'd7, 32'h11, 5'd3, 1, 0, 0);

        step();
        expect_now("reset1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        expect_now("reset2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ADD r3 = r1 + r2 now in EX; decode SUB r4 = r3 - r2 with stale r3 data
        step();
        set_id(1, 6'd2, 5'd3, 32'h99, 5'd2, 32'd7, 32'h0, 5'd4, 1, 0, 0);
        expect_now("add", 1, 6'd1, 1, 0, 0, 5'd3, 32'd5, 32'd7, 32'h11, 0, 0);

        // SUB in EX, ADD result sits in EX/MEM
        step();
        set_exm(1, 1, 5'd3, 32'h10);
        set_id(1, 6'd1, 5'd3, 32'h55, 5'd0, 32'h0, 32'h4, 5'd6, 1, 0, 0);
        expect_now("sub_fwd_exm", 1, 6'd2, 1, 0, 0, 5'd4, 32'h10, 32'd7, 32'h0, 0, 0);

        // Both stages write r3: EX/MEM is younger and wins
        step();
        set_mwb(1, 1, 5'd3, 32'h20);
        set_id(1, 6'd1, 5'd0, 32'h0, 5'd3, 32'h77, 32'h0, 5'd7, 1, 0, 0);
        expect_now("fwd_prio", 1, 6'd1, 1, 0, 0, 5'd6, 32'h10, 32'h0, 32'h4, 0, 0);

        // EX/MEM writes r0 (must not forward to rs1=r0); rs2=r3 comes from MEM/WB
        step();
        set_exm(1, 1, 5'd0, 32'hdead);
        set_id(0, 6'd3, 5'd3, 32'h44, 5'd3, 32'h45, 32'h9, 5'd8, 0, 0, 1);
        expect_now("r0_mwb", 1, 6'd1, 1, 0, 0, 5'd7, 32'h0, 32'h20, 32'h0, 0, 0);

        // Invalid slot: control captured, but operands gated to zero despite a matching producer
        step();
        set_exm(1, 1, 5'd3, 32'h10);
        set_mwb(0, 0, 0, 0);
        set_id(1, 6'd1, 5'd1, 32'h100, 5'd0, 32'h0, 32'h4, 5'd5, 1, 1, 0);
        expect_now("invalid_gate", 0, 6'd3, 0, 0, 1, 5'd8, 32'h0, 32'h0, 32'h9, 0, 0);

        // LOAD r5 in EX; decode ADD r9 = r5 + r2 creates a load-use hazard
        step();
        set_exm(0, 0, 0, 0);
        set_id(1, 6'd1, 5'd5, 32'h0, 5'd2, 32'd7, 32'h0, 5'd9, 1, 0, 0);
        expect_now("load_hazard", 1, 6'd1, 1, 1, 0, 5'd5, 32'h100, 32'h0, 32'h4, 1, 0);

        // Bubble issued, ADD held in decode
        step();
        expect_now("stall_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd1);

        // Held ADD issues; load data forwarded from MEM/WB
        step();
        set_mwb(1, 1, 5'd5, 32'h1234);
        set_id(1, 6'd1, 5'd1, 32'h100, 5'd0, 32'h0, 32'h4, 5'd5, 1, 1, 0);
        expect_now("held_issue", 1, 6'd1, 1, 0, 0, 5'd9, 32'h1234, 32'd7, 32'h0, 0, 8'd1);

        // Load in EX again, hazard on rs2 coincides with flush
        step();
        set_mwb(0, 0, 0, 0);
        set_id(1, 6'd1, 5'd2, 32'd7, 5'd5, 32'h0, 32'h0, 5'd9, 1, 0, 0);
        flush = 1'b1;
        expect_now("flush_hazard", 1, 6'd1, 1, 1, 0, 5'd5, 32'h100, 32'h0, 32'h4, 0, 8'd1);

        step();
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_now("flush_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd1);

        // Repeated load-use stalls drive the counter into saturation
        exp_cnt = 8'd1;
        for (int i = 0; i < 300; i++) begin
            step();
            set_id(1, 6'd1, 5'd1, 32'h100, 5'd0, 32'h0, 32'h4, 5'd5, 1, 1, 0);
            step();
            set_id(1, 6'd1, 5'd5, 32'h0, 5'd2, 32'd7, 32'h0, 5'd9, 1, 0, 0);
            if (i == 299) begin
                expect_now("sat_stall", 1, 6'd1, 1, 1, 0, 5'd5, 32'h100, 32'h0, 32'h4, 1, exp_cnt);
            end
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        end
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_now("sat_final", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp_cnt);
        if (exp_cnt != 8'hFF) begin
            checks++;
            errors++;
            $display("FAIL sat_model got %h want ff", exp_cnt);
        end

        step();
        step();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never checked (due cycle %0d)", e.nm, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
